// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with byte FIFO and sticky overflow flag.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit, STATUS bit 4 set).
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int CLKS_PER_BIT = 1085,
  parameter int DEPTH = 16
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        core_tick,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  input  logic        write_en,
  output logic [31:0] rd_data,
  output logic        txd,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam logic PAR_EN = 1'b0;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count, count_n;
  logic full, empty, ovf, push, pop, wr_data, wr_stat, last, txd_n;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  assign wr_data = core_tick & write_en & (addr == BASE_ADDR);
  assign wr_stat = core_tick & write_en & (addr == BASE_ADDR + 32'd4);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // full is judged on the pre-pop count, so a push is dropped even if a pop coincides
  assign push = wr_data & ~full;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  assign last = cnt == LAST;
  assign rd_data = {27'b0, PAR_EN, ovf, full, empty, busy};
  always_ff @(posedge sysclk)
    if (push) mem[wptr] <= data_i[7:0];
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      wptr <= push ? wptr + AW'(1) : wptr;
      rptr <= pop ? rptr + AW'(1) : rptr;
      count <= count_n;
      ovf <= (ovf & ~wr_stat) | (wr_data & full);
    end
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      txd <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= shreg_n;
      txd <= txd_n;
      busy <= (state_n != IDLE) || (count_n != '0);
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + CW'(1);
    idx_n = idx;
    shreg_n = shreg;
    txd_n = txd;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        txd_n = empty;
        pop = ~empty;
        shreg_n = empty ? shreg : mem[rptr];
        state_n = empty ? IDLE : START;
      end
      START: if (last) begin
        state_n = DATA;
        idx_n = '0;
        txd_n = shreg[0];
      end
      DATA: if (last) begin
        idx_n = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
        state_n = (idx == 3'd7) ? PARITY : DATA;
        txd_n = (idx == 3'd7) ? ^shreg : shreg[idx + 3'd1];
`else
        state_n = (idx == 3'd7) ? STOP : DATA;
        txd_n = (idx == 3'd7) ? 1'b1 : shreg[idx + 3'd1];
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (last) begin
        state_n = STOP;
        txd_n = 1'b1;
      end
`endif
      // back-to-back frames: the next byte is popped straight out of STOP
      STOP: if (last) begin
        pop = ~empty;
        shreg_n = empty ? shreg : mem[rptr];
        state_n = empty ? IDLE : START;
        txd_n = empty;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench; a monitor decodes txd frames and pops expected bytes.
module tb_uart_tx_mmio;
  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] P = 32'h10;
`else
  localparam int NB = 10;
  localparam logic [31:0] P = 32'h0;
`endif
  logic sysclk = 1'b0, reset = 1'b1, core_tick = 1'b0, write_en = 1'b0, txd, busy;
  logic [31:0] addr = '0, data_i = '0, rd_data;
  int n_checks = 0, n_fail = 0, frames = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
    .sysclk(sysclk), .reset(reset), .core_tick(core_tick), .addr(addr), .data_i(data_i),
    .write_en(write_en), .rd_data(rd_data), .txd(txd), .busy(busy));

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // frame as transmitted, bit 0 first: start, data LSB first, [parity], stop
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b01, b, 1'b0};
`endif
  endfunction

  task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic we, input logic tk);
    addr = a;
    data_i = {$urandom_range(0, 32'hff_ffff), d} ;
    write_en = we;
    core_tick = tk;
    @(negedge sysclk);
    write_en = 1'b0;
    core_tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge sysclk);
      k++;
    end
    check("idle_timeout", {31'b0, busy}, 32'h0);
    repeat (2) @(negedge sysclk);
  endtask

  initial begin : monitor
    logic [10:0] bits;
    logic ok, abort;
    logic [7:0] e;
    forever begin
      @(negedge sysclk);
      if (!reset && txd === 1'b0) begin
        bits = '0;
        ok = 1'b1;
        abort = 1'b0;
        starts.push_back(cyc);
        for (int j = 0; j < NB * CPB; j++) begin
          if (j > 0) @(negedge sysclk);
          if (reset) abort = 1'b1;
          if (j % CPB == 0) bits[j / CPB] = txd;
          else if (txd !== bits[j / CPB]) ok = 1'b0;
        end
        if (!abort) begin
          if (exp_q.size() == 0) check("unexpected_frame", {21'b0, bits}, 32'h0);
          else begin
            e = exp_q.pop_front();
            check("frame", {20'b0, ok, bits}, {20'b0, 1'b1, frame_of(e)});
          end
          frames++;
        end
      end
    end
  end

  initial begin : stim
    int k, first_low, drop, f0, s0, n, gap, total;
    logic [7:0] b;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    check("rst_txd", {31'b0, txd}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_status", rd_data, 32'h2 | P);

    exp_q.push_back(8'hA5);
    bus(BASE, 8'hA5, 1'b1, 1'b1);
    check("push_status", rd_data, 32'h1 | P);
    k = 1; first_low = -1; drop = -1;
    while (k < 200 && drop < 0) begin
      if (txd === 1'b0 && first_low < 0) first_low = k;
      if (k > 1 && busy === 1'b0) drop = k;
      @(negedge sysclk);
      k++;
    end
    check("start_latency", first_low, 2);
    check("busy_drop", drop, 2 + NB * CPB);
    repeat (2) @(negedge sysclk);

    s0 = starts.size();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    bus(BASE, 8'h01, 1'b1, 1'b1);
    bus(BASE, 8'h02, 1'b1, 1'b1);
    wait_idle(500);
    check("b2b_frames", starts.size() - s0, 2);
    if (starts.size() - s0 == 2) check("b2b_gap", starts[s0 + 1] - starts[s0], NB * CPB);

    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      b = 8'h30 + 8'(i);
      if (i < DEP + 1) exp_q.push_back(b);
      bus(BASE, b, 1'b1, 1'b1);
    end
    check("ovf_status", rd_data, 32'hD | P);
    bus(BASE + 32'd4, 8'hFF, 1'b1, 1'b1);
    check("ovf_clear", rd_data, 32'h5 | P);
    wait_idle(1000);
    check("ovf_frames", frames - f0, 5);

    f0 = frames;
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 8; i++) bus(BASE, 8'h5A, 1'b1, i == 3);
    wait_idle(500);
    check("qual_frames", frames - f0, 1);
    f0 = frames;
    bus(BASE + 32'd8, 8'h77, 1'b1, 1'b1);
    repeat (60) @(negedge sysclk);
    check("other_addr_frames", frames - f0, 0);
    check("other_addr_status", rd_data, 32'h2 | P);

    f0 = frames; total = 0;
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, DEP + 1);
      for (int i = 0; i < n; i++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++)
          if ($urandom_range(0, 1) == 1) bus(BASE, 8'($urandom), 1'b1, 1'b0);
          else bus(BASE + 32'd8 + 32'($urandom_range(0, 15)) * 4, 8'($urandom), 1'b1, 1'b1);
        b = 8'($urandom);
        exp_q.push_back(b);
        bus(BASE, b, 1'b1, 1'b1);
        total++;
      end
      wait_idle(2000);
    end
    check("rand_frames", frames - f0, total);
    check("rand_status", rd_data, 32'h2 | P);

    exp_q.push_back(8'h3C);
    bus(BASE, 8'h3C, 1'b1, 1'b1);
    repeat (15) @(negedge sysclk);
    reset = 1'b1;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    exp_q.delete();
    check("midrst_txd", {31'b0, txd}, 32'h1);
    check("midrst_status", rd_data, 32'h2 | P);
    repeat (60) @(negedge sysclk);
    check("final_queue", exp_q.size(), 0);
    check("final_txd", {31'b0, txd}, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped 8N1 UART transmitter hanging off the core's data-memory port B, alongside main memory and the TFT text window. Runs on `sysclk`, samples core-domain bus writes via a one-cycle `core_tick` qualifier, and buffers bytes in a FIFO. Bytes are serialised on `txd` at a fixed baud set by a divider. It is the console output path for firmware and test programs.

## Interface
- `BASE_ADDR`, `32'h4000_0000`: byte address of the DATA register. STATUS is at `BASE_ADDR+4`.
- `CLKS_PER_BIT`, `1085`: `sysclk` cycles per serial bit; 125 MHz / 115200. Must be ≥ 2.
- `DEPTH`, `16`: FIFO entries. Power of two, ≥ 2.

Ports:
- `sysclk` in, 1: clock.
- `reset` in, 1: reset, synchronous, active-high.
- `core_tick` in, 1: one-`sysclk`-cycle pulse per core clock rising edge. Bus inputs are sampled only when it is high.
- `addr` in, 32: dmem port B address.
- `data_i` in, 32: dmem port B write data. Only bits [7:0] are used.
- `write_en` in, 1: dmem port B write enable.
- `rd_data` out, 32: STATUS value, combinational from registered state.
- `txd` out, 1: serial output, idle high.
- `busy` out, 1: serialiser not in IDLE, or FIFO non-empty.

## Operation
- **DATA write:** `core_tick & write_en & addr==BASE_ADDR`.
  - Pushes `data_i[7:0]` if the FIFO is not full.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
- **STATUS write:** `core_tick & write_en & addr==BASE_ADDR+4`. Clears `ovf`; data is ignored.
- **STATUS read:** `rd_data = {28'b0, ovf, full, empty, busy}` (bits 3..0). The value is independent of `addr`; the top level muxes it.
- **FIFO:** circular buffer with read and write pointers of log2(DEPTH) bits each, which wrap. The count is log2(DEPTH)+1 bits. `full` is `count==DEPTH`; `empty` is `count==0`.
- **Simultaneous push and pop:**
  - The full test uses the pre-pop count, so a push is dropped when full even if a pop occurs in the same cycle.
  - On a simultaneous push and pop, the count is unchanged.
- **Serialiser FSM:** states IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. That cycle pops the head into `shreg`, clears the baud counter, and sets `txd=0` from the next cycle.
  - START: hold `txd=0` for CLKS_PER_BIT cycles, then → DATA with bit index 0.
  - DATA: drive `shreg[idx]` LSB first. Each bit lasts CLKS_PER_BIT cycles. After idx 7 → STOP.
  - STOP: `txd=1` for CLKS_PER_BIT cycles. At the end: if the FIFO is non-empty, pop and → START directly with no idle gap; otherwise → IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).
- Writes with `core_tick` low, or to other addresses, are ignored.

## Timing
- **Reset values:** `txd=1`, `busy=0`, `rd_data=32'h2` (empty=1). Also FIFO pointers and count 0, `ovf=0`, FSM IDLE, baud counter 0.
- **Reset mid-frame:** on the next edge `txd` returns high and the FIFO is flushed. There is no partial-frame completion.
- **Push latency:** the FIFO count updates on the edge at which the write is sampled. `empty` deasserts in the following cycle.
- **Start latency:** with an idle serialiser and an empty FIFO, `txd` falls 2 `sysclk` cycles after the sampled write cycle (push edge, then pop edge).
- **Frame length:** exactly 10×CLKS_PER_BIT cycles. Back-to-back frames have no extra idle cycles.
- `busy` is registered and deasserts in the first IDLE cycle with the FIFO empty.
- **Duplicate writes:** a write held across several `sysclk` cycles is accepted once per `core_tick` pulse. Firmware relies on `core_tick` for de-duplication.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - The FSM gains a PARITY state between DATA and STOP, driving even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - The frame becomes 11 bits (8E1).
  - STATUS bit 4 reads 1 to advertise parity.
- **Undefined:** 8N1, no PARITY state, and STATUS bit 4 reads 0.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DEPTH=4.
- **Reset:** assert reset for 3 cycles → `txd=1`, `busy=0`, `rd_data=32'h2`. Then pulse reset mid-frame → `txd=1` on the next cycle and `rd_data=32'h2`.
- **Single byte:** write 0xA5 to DATA with one `core_tick` → `txd` falls 2 cycles later. Bits observed every 4 cycles are 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). `busy` drops at cycle 2+40.
- **Back-to-back:** write 0x01 then 0x02 on consecutive ticks → the two frames are contiguous, with the second start bit immediately after the first stop bit, 80 cycles total.
- **Overflow:**
  - Write 6 bytes rapidly while the first frame is in progress → 1 popped, 4 queued, 1 dropped. STATUS shows `ovf=1, full=1`.
  - A STATUS write clears `ovf`.
  - Exactly 5 frames are emitted.
- **Qualification:** hold `write_en` with a DATA address for 8 cycles with a single `core_tick` pulse → exactly one frame. A write to `BASE_ADDR+8` → no frame, and STATUS is unchanged.
- **Parity (with `UART_TX_PARITY_EN`):** write 0x07 → parity bit 1, 44-cycle frame, STATUS bit 4 = 1.
